// File: rtl/sa48_pkg.sv
// sa48_pkg: shared configuration for the chunked 48-bit serial adder.
//   CHUNK_W    - width of one operand chunk and of the chunk adder
//   NUM_CHUNKS - chunks per operand (result width CHUNK_W*NUM_CHUNKS)
//   state_e    - controller states
package sa48_pkg;

  localparam int unsigned CHUNK_W    = 12;
  localparam int unsigned NUM_CHUNKS = 4;

  typedef enum logic {
    IDLE,
    ACC
  } state_e;

endpackage

// File: rtl/cla12.sv
// cla12: 12-bit unsigned carry-lookahead adder.
// Three 4-bit generate/propagate groups with a second lookahead level across the groups.
// Ports:
//   a, b - 12-bit operands
//   cin  - carry into bit 0
//   sum  - 12-bit sum
//   cout - carry out of bit 11
module cla12 (
  input  logic [11:0] a,
  input  logic [11:0] b,
  input  logic        cin,
  output logic [11:0] sum,
  output logic        cout
);

  logic [11:0] g;
  logic [11:0] p;
  logic [11:0] c;
  logic [2:0]  grp_g;
  logic [2:0]  grp_p;
  logic [3:0]  grp_c;  // carry into each group, grp_c[3] is the final carry-out

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < 3; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
    end
  end

  always_comb begin
    grp_c[0] = cin;
    grp_c[1] = grp_g[0] | (grp_p[0] & cin);
    grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
    grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
  end

  // Bit carries inside each group are looked ahead from that group's carry-in.
  always_comb begin
    c = '0;
    for (int k = 0; k < 3; k++) begin
      c[4*k]   = grp_c[k];
      c[4*k+1] = g[4*k] | (p[4*k] & grp_c[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & grp_c[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
    end
  end

  assign sum  = p ^ c;
  assign cout = grp_c[3];

endmodule

// File: rtl/sa48.sv
// sa48: chunk-serial 48-bit adder. Operands arrive CHUNK_W bits per cycle, least-significant
// chunk first, and are summed through a single carry-lookahead chunk adder with the carry held
// between cycles.
// Build option: define SA48_CI_EN to use ci as the chunk-0 carry-in; otherwise it is forced to 0
// and ci is left unused.
// Ports:
//   clk         - clock, rising edge
//   rst         - asynchronous active-low reset
//   inBusA      - operand A chunk
//   inBusB      - operand B chunk
//   startChunks - marks the cycle carrying chunk 0; also abandons any operation in flight
//   ci          - carry-in, sampled with chunk 0
//   outBus      - registered sum
//   resultReady - one-cycle pulse when outBus/co hold a completed result
//   co          - registered carry-out of the full-width add
module sa48 #(
  parameter int unsigned CHUNK_W    = sa48_pkg::CHUNK_W,
  parameter int unsigned NUM_CHUNKS = sa48_pkg::NUM_CHUNKS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHUNK_W-1:0]            inBusA,
  input  logic [CHUNK_W-1:0]            inBusB,
  input  logic                          startChunks,
  input  logic                          ci,
  output logic [CHUNK_W*NUM_CHUNKS-1:0] outBus,
  output logic                          resultReady,
  output logic                          co
);

  import sa48_pkg::*;

  localparam int unsigned RES_W        = CHUNK_W * NUM_CHUNKS;
  localparam int unsigned IDX_W        = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [RES_W-1:0] out_q, out_d;
  logic             co_q, co_d;
  logic             ready_q, ready_d;

  logic               first_cin;
  logic               add_cin;
  logic [CHUNK_W-1:0] add_sum;
  logic               add_cout;

`ifdef SA48_CI_EN
  assign first_cin = ci;
`else
  logic unused_ci;
  assign unused_ci = ci;
  assign first_cin = 1'b0;
`endif

  // A start always takes priority, so chunk 0 uses the external carry-in even mid-operation.
  assign add_cin = startChunks ? first_cin : carry_q;

  cla12 u_cla12 (
    .a    (inBusA),
    .b    (inBusB),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    out_d   = out_q;
    co_d    = co_q;
    ready_d = 1'b0;

    if (startChunks) begin
      out_d                = '0;
      out_d[CHUNK_W-1:0]   = add_sum;
      carry_d              = add_cout;
      idx_d                = IDX_W'(1);
      state_d              = ACC;
    end else if (state_q == ACC) begin
      out_d[idx_q*CHUNK_W +: CHUNK_W] = add_sum;
      carry_d                         = add_cout;
      if (idx_q == LAST_IDX) begin
        co_d    = add_cout;
        ready_d = 1'b1;
        idx_d   = '0;
        state_d = IDLE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      out_q   <= '0;
      co_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      out_q   <= out_d;
      co_q    <= co_d;
      ready_q <= ready_d;
    end
  end

  assign outBus      = out_q;
  assign co          = co_q;
  assign resultReady = ready_q;

endmodule

// File: tb/tb_sa48.sv
// tb_sa48: randomized self-checking bench for sa48 against a whole-operand arithmetic model.
module tb_sa48;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] inBusA;
  logic [11:0] inBusB;
  logic        startChunks;
  logic        ci;
  logic [47:0] outBus;
  logic        resultReady;
  logic        co;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic        early_ready;
  logic [48:0] last_exp;

  sa48 dut (
    .clk         (clk),
    .rst         (rst),
    .inBusA      (inBusA),
    .inBusB      (inBusB),
    .startChunks (startChunks),
    .ci          (ci),
    .outBus      (outBus),
    .resultReady (resultReady),
    .co          (co)
  );

  always #5 clk = ~clk;

  // Reference: full-width unsigned add; bit 48 is the carry-out.
  function automatic logic [48:0] model_sum(input logic [47:0] a, input logic [47:0] b,
                                            input logic c);
    logic use_ci;
`ifdef SA48_CI_EN
    use_ci = 1'b1;
`else
    use_ci = 1'b0;
`endif
    return {1'b0, a} + {1'b0, b} + ((use_ci && c) ? 49'd1 : 49'd0);
  endfunction

  task automatic idle_inputs();
    startChunks = 1'b0;
    inBusA      = 12'($urandom);
    inBusB      = 12'($urandom);
    ci          = 1'($urandom);
  endtask

  // Drives one full operation; returns 1 time unit after the edge that captures the last chunk.
  task automatic apply_op(input logic [47:0] a, input logic [47:0] b, input logic c);
    early_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      inBusA      = a[12*i +: 12];
      inBusB      = b[12*i +: 12];
      startChunks = (i == 0);
      ci          = (i == 0) ? c : 1'($urandom);
      @(posedge clk);
      #1;
      if (i < 3 && resultReady) early_ready = 1'b1;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    #12;
    n_cmp++;
    if (outBus !== 48'h0) begin
      n_fail++; $display("FAIL reset_out: got %h want %h", outBus, 48'h0);
    end
    n_cmp++;
    if (co !== 1'b0 || resultReady !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got co=%b rdy=%b want 0 0", co, resultReady);
    end
    // A start while held in reset must not take effect.
    startChunks = 1'b1;
    inBusA = 12'hABC;
    inBusB = 12'h123;
    @(posedge clk);
    #1;
    n_cmp++;
    if (outBus !== 48'h0) begin
      n_fail++; $display("FAIL reset_hold_out: got %h want %h", outBus, 48'h0);
    end
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    logic [48:0] exp_ones;
    // First start lands on the first edge after reset release.
    apply_op({12'h020, 12'h7D0, 12'h00D, 12'h801}, {12'h013, 12'hFFF, 12'h01D, 12'h065}, 1'b0);
    n_cmp++;
    if (early_ready !== 1'b0 || resultReady !== 1'b1) begin
      n_fail++; $display("FAIL dir_ready_timing: got early=%b rdy=%b want 0 1", early_ready,
                         resultReady);
    end
    n_cmp++;
    if ({co, outBus} !== {1'b0, 48'h0347CF02A866}) begin
      n_fail++; $display("FAIL dir_sum: got co=%b %h want co=0 0347cf02a866", co, outBus);
    end

`ifdef SA48_CI_EN
    exp_ones = {1'b1, 48'hFFFFFFFFFFFF};
`else
    exp_ones = {1'b1, 48'hFFFFFFFFFFFE};
`endif
    apply_op(48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 1'b1);
    n_cmp++;
    if (resultReady !== 1'b1 || {co, outBus} !== exp_ones) begin
      n_fail++; $display("FAIL all_ones: got rdy=%b co=%b %h want rdy=1 co=%b %h", resultReady,
                         co, outBus, exp_ones[48], exp_ones[47:0]);
    end

    apply_op({12'h000, 12'hFFF, 12'hFFF, 12'hFFF}, 48'h000000000001, 1'b0);
    n_cmp++;
    if (resultReady !== 1'b1 || {co, outBus} !== {1'b0, 48'h001000000000}) begin
      n_fail++; $display("FAIL ripple: got rdy=%b co=%b %h want rdy=1 co=0 001000000000",
                         resultReady, co, outBus);
    end
    last_exp = {1'b0, 48'h001000000000};
  endtask

  task automatic test_random();
    logic [47:0] a, b;
    logic        c;
    logic [48:0] exp;
    int          gap;
    for (int n = 0; n < 30; n++) begin
      gap = int'($urandom_range(0, 3));
      for (int k = 0; k < gap; k++) begin
        idle_inputs();
        @(posedge clk);
        #1;
        n_cmp++;
        if (resultReady !== 1'b0 || {co, outBus} !== last_exp) begin
          n_fail++; $display("FAIL idle_hold: got rdy=%b co=%b %h want rdy=0 co=%b %h",
                             resultReady, co, outBus, last_exp[48], last_exp[47:0]);
        end
      end
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      c   = 1'($urandom);
      exp = model_sum(a, b, c);
      apply_op(a, b, c);
      n_cmp++;
      if (early_ready !== 1'b0 || resultReady !== 1'b1 || {co, outBus} !== exp) begin
        n_fail++; $display("FAIL rand_op%0d: got early=%b rdy=%b co=%b %h want 0 1 co=%b %h", n,
                           early_ready, resultReady, co, outBus, exp[48], exp[47:0]);
      end
      last_exp = exp;
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] a, b;
    logic [48:0] exp;
    for (int n = 0; n < 3; n++) begin
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      exp = model_sum(a, b, 1'b1);
      apply_op(a, b, 1'b1);
      n_cmp++;
      if (early_ready !== 1'b0 || resultReady !== 1'b1 || {co, outBus} !== exp) begin
        n_fail++; $display("FAIL b2b_op%0d: got early=%b rdy=%b co=%b %h want 0 1 co=%b %h", n,
                           early_ready, resultReady, co, outBus, exp[48], exp[47:0]);
      end
    end
    last_exp = exp;
  endtask

  task automatic test_reset_mid();
    inBusA = 12'h5A5; inBusB = 12'h777; startChunks = 1'b1; ci = 1'b1;
    @(posedge clk);
    #1;
    inBusA = 12'hFFF; inBusB = 12'h001; startChunks = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (outBus !== 48'h0 || co !== 1'b0 || resultReady !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_now: got co=%b rdy=%b %h want 0 0 0", co, resultReady,
                         outBus);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      idle_inputs();
      @(posedge clk);
      #1;
      n_cmp++;
      if (resultReady !== 1'b0 || outBus !== 48'h0 || co !== 1'b0) begin
        n_fail++; $display("FAIL mid_reset_after%0d: got rdy=%b co=%b %h want 0 0 0", k,
                           resultReady, co, outBus);
      end
    end
    last_exp = '0;
  endtask

  task automatic test_restart();
    logic [47:0] a1, b1, a2, b2;
    logic [48:0] exp;
    a1 = {$urandom, $urandom};
    b1 = {$urandom, $urandom};
    a2 = {$urandom, $urandom};
    b2 = {$urandom, $urandom};
    exp = model_sum(a2, b2, 1'b1);
    for (int i = 0; i < 2; i++) begin
      inBusA      = a1[12*i +: 12];
      inBusB      = b1[12*i +: 12];
      startChunks = (i == 0);
      ci          = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (resultReady !== 1'b0) begin
        n_fail++; $display("FAIL restart_old%0d: got rdy=%b want 0", i, resultReady);
      end
    end
    apply_op(a2, b2, 1'b1);
    n_cmp++;
    if (early_ready !== 1'b0 || resultReady !== 1'b1 || {co, outBus} !== exp) begin
      n_fail++; $display("FAIL restart_new: got early=%b rdy=%b co=%b %h want 0 1 co=%b %h",
                         early_ready, resultReady, co, outBus, exp[48], exp[47:0]);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (resultReady !== 1'b0 || {co, outBus} !== exp) begin
      n_fail++; $display("FAIL restart_pulse_end: got rdy=%b co=%b %h want 0 co=%b %h",
                         resultReady, co, outBus, exp[48], exp[47:0]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sa48.md
SA48 -- requirements
Module: sa48

Interface
REQ-001 SHALL have parameter CHUNK_W, default 12, meaning width of one input chunk and of the internal adder.
REQ-002 SHALL have parameter NUM_CHUNKS, default 4, meaning chunks per operand; result width is CHUNK_W*NUM_CHUNKS (48).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port inBusA, input, 12 bits: operand A chunk, least-significant chunk first.
REQ-006 SHALL have port inBusB, input, 12 bits: operand B chunk, same order as inBusA.
REQ-007 SHALL have port startChunks, input, 1 bit: high in the cycle that carries chunk 0.
REQ-008 SHALL have port ci, input, 1 bit: carry-in to chunk 0, sampled with chunk 0.
REQ-009 SHALL have port outBus, output, 48 bits: registered 48-bit sum.
REQ-010 SHALL have port resultReady, output, 1 bit: one-cycle pulse marking outBus/co valid.
REQ-011 SHALL have port co, output, 1 bit: registered carry-out of the 48-bit add.

Function
REQ-012 SHALL use a two-state FSM: IDLE and ACC, with a chunk index register idx in 0..NUM_CHUNKS-1.
REQ-013 SHALL, at a rising edge with startChunks=1 in any state, add inBusA+inBusB+ci, write the 12-bit sum to outBus[11:0], clear outBus[47:12], store the carry, set idx=1, and go to ACC.
REQ-014 SHALL, in ACC at each edge with startChunks=0, add inBusA+inBusB+stored carry, write the sum to outBus[12*idx+:12], update the stored carry, and increment idx.
REQ-015 SHALL accept chunks 1..3 on the three consecutive edges after the start edge; startChunks is not required during them.
REQ-016 SHALL, on the edge that captures chunk 3, load co with that chunk's carry-out, set resultReady=1, and return to IDLE.
REQ-017 SHALL drive resultReady high for exactly one cycle, 3 cycles after the start edge; 4 edges in total from first to last chunk.
REQ-018 SHALL hold outBus and co unchanged in IDLE until the next start.
REQ-019 SHALL ignore inBusA, inBusB and ci in IDLE when startChunks=0.
REQ-020 SHALL treat startChunks=1 during ACC as abandoning the current operation and starting a new one per REQ-013; no resultReady is issued for the abandoned operation.
REQ-021 SHALL compute each chunk sum with an unsigned 12-bit carry-lookahead adder; results wrap modulo 2^48, and overflow is reported only through co.

Reset
REQ-022 SHALL, while rst=0, immediately force outBus=0, co=0, resultReady=0, stored carry=0, idx=0, and state=IDLE, including in the middle of an operation.
REQ-023 SHALL accept a start on the first rising edge after rst deasserts.

Configuration
REQ-024 SHALL, when macro SA48_CI_EN is defined, use ci as the chunk-0 carry-in.
REQ-025 SHALL, when SA48_CI_EN is undefined, force the chunk-0 carry-in to 0; the ci port remains present and unused.

Structure
REQ-026 SHALL place CHUNK_W, NUM_CHUNKS and the FSM state enum typedef in package sa48_pkg.
REQ-027 SHALL instantiate one sub-module cla12: a 12-bit carry-lookahead adder built from three 4-bit generate/propagate groups with group lookahead, with ports a, b, cin, sum and cout.

Verification
REQ-028 SHALL cover reset then start: chunks (A,B) = (2049,101), (13,29), (2000,4095), (32,19) with ci=0 -> resultReady pulses 3 cycles after start, outBus=48'h0347CF02A866, co=0.
REQ-029 SHALL cover the all-ones case: four chunks A=B=12'hFFF with ci=1 (SA48_CI_EN defined) -> outBus=48'hFFFFFFFFFFFF, co=1; with the macro undefined -> outBus=48'hFFFFFFFFFFFE, co=1.
REQ-030 SHALL cover carry ripple across chunks: A chunks {FFF,FFF,FFF,000} and B chunks {001,000,000,000} -> outBus=48'h001000000000, co=0.
REQ-031 SHALL cover reset mid-operation: rst=0 after chunk 1 -> outBus=0, co=0, resultReady=0 at once; no pulse follows.
REQ-032 SHALL cover restart: startChunks=1 again at chunk 2 -> only the new operation completes, with resultReady 3 cycles after the second start and outBus holding only the new sum.
